data_cache_refill_unit: RTL and testbench
=========================================

// Module: data_cache_refill_unit
// PURPOSE
//  Line-refill sequencer for the data cache. On a miss it fetches one cache block from memory word
//  by word and writes it into the selected data_cache_way through that way's port 0 (R/W).
//  Sits between the miss-detection logic (upstream) and the cache ways (downstream).
//  Store misses merge their data after done_o; this block does not merge.
// PARAMETERS
//  WORD_WIDTH   32  data word width (bits)
//  BLOCK_WORDS  4   words per cache block = data chips per way; power of 2, >=2
//  INDEX_BITS   8   set index width
//  TAG_BITS     20  tag width; TAG_BITS+INDEX_BITS+log2(BLOCK_WORDS)+2 = 32
//  WAYS         4   number of ways, one-hot select
//  REFILL_TIMEOUT 256 cycles without handshake progress before abort (macro only)
// PORTS
//  clk_i            in   1           clock, all state on rising edge
//  rst_n_i          in   1           asynchronous active-low reset
//  miss_req_i       in   1           refill request; held until accepted
//  miss_address_i   in   32          faulting byte address
//  miss_way_i       in   WAYS        one-hot victim way
//  miss_store_i     in   1           1 = store miss, line committed dirty
//  miss_ready_o     out  1           1 in IDLE; accept = miss_req_i & miss_ready_o
//  mem_req_o        out  1           block read request, held until mem_ack_i
//  mem_address_o    out  32          block-aligned address (offset bits zero)
//  mem_ack_i        in   1           memory accepted request
//  mem_valid_i      in   1           one data word valid this cycle
//  mem_data_i       in   WORD_WIDTH  refill word, ascending offset order
//  enable_way_o     out  WAYS        way enable to data_cache_way
//  port0_write_o    out  1           port 0 write strobe
//  port0_enable_o   out  4           {valid,dirty,tag,data} field enables
//  port0_chip_select_o out log2(BLOCK_WORDS) target data chip
//  port0_byte_write_o out WORD_WIDTH/8 byte enables, all ones when writing
//  port0_address_o  out  INDEX_BITS  set index
//  port0_word_o     out  WORD_WIDTH  word to write
//  port0_tag_o      out  TAG_BITS    tag to write
//  port0_valid_o / port0_dirty_o out 1 status bits to write
//  busy_o           out  1           state != IDLE
//  done_o           out  1           1-cycle pulse, line committed
//  refill_error_o   out  1           1-cycle pulse, refill aborted
// BEHAVIOUR
//  Reset: state IDLE, counter 0, captured regs 0; all outputs 0 except miss_ready_o=1.
//  States: IDLE -> INVALIDATE -> REQUEST -> RECEIVE -> COMMIT -> IDLE.
//  IDLE: on accept, register index/tag/way/store from miss_*; no other effect.
//  INVALIDATE (1 cycle): port0_write_o=1, enable={1,0,0,0}, valid=0; line never hits while partial.
//  REQUEST: mem_req_o=1, mem_address_o stable; mem_ack_i=1 -> RECEIVE (cycle of ack counts).
//  RECEIVE: each mem_valid_i cycle writes mem_data_i to chip=counter, enable={0,0,0,1},
//   byte_write all ones, counter++; word BLOCK_WORDS-1 -> COMMIT, counter wraps to 0.
//   Cycles without mem_valid_i: port0_write_o=0, no state change.
//  COMMIT (1 cycle): write enable={1,1,1,0}, valid=1, dirty=store, tag; done_o=1; -> IDLE.
//  Minimum latency: accept at T, done_o at T+BLOCK_WORDS+3 (ack and words back-to-back).
//  port0_* and enable_way_o driven from registered state; zero outside write cycles.
//  mem_valid_i outside RECEIVE and mem_ack_i outside REQUEST: ignored.
//  miss_req_i while busy: not accepted, ready low; requester holds.
//  Reset mid-refill: immediate return to IDLE, no commit; line stays invalid if already invalidated.
// CONFIGURATION
//  DCACHE_REFILL_TIMEOUT_EN defined: counter reloads on accept/ack/mem_valid_i; reaching
//   REFILL_TIMEOUT in REQUEST or RECEIVE -> refill_error_o pulse, no COMMIT, line invalid, IDLE.
//  Undefined: no watchdog, waits indefinitely; refill_error_o tied 0 (port always present).
// TESTING
//  Load miss addr 0x0000_1230 way 0b0010, ack same cycle, 4 back-to-back words -> chips 0..3,
//   index 0x23, commit tag 0x00001 valid=1 dirty=0, done_o at T+7.
//  Store miss, mem_valid_i gaps of 3 cycles between words -> same writes, dirty=1, done_o delayed 9.
//  miss_req_i held high during refill -> second request accepted cycle after done_o, not before.
//  Stray mem_valid_i in IDLE/REQUEST -> no port0 write, counter unchanged.
//  rst_n_i low after word 2 -> all outputs reset async, no COMMIT, next miss restarts at chip 0.
//  With DCACHE_REFILL_TIMEOUT_EN, no mem_ack_i for 256 cycles -> refill_error_o pulse, no COMMIT.

Source files
------------

// File: rtl/data_cache_refill_unit_if.sv
// Handshake and bus bundle between the refill sequencer, the miss logic, memory and the cache ways.
// The master modport is the refill unit's view; slave is its environment.
interface data_cache_refill_unit_if #(
  parameter int WORD_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int INDEX_BITS  = 8,
  parameter int TAG_BITS    = 20,
  parameter int WAYS        = 4
);
  localparam int CHIP_BITS = $clog2(BLOCK_WORDS);

  logic                    miss_req_i;
  logic [31:0]             miss_address_i;
  logic [WAYS-1:0]         miss_way_i;
  logic                    miss_store_i;
  logic                    miss_ready_o;
  logic                    mem_req_o;
  logic [31:0]             mem_address_o;
  logic                    mem_ack_i;
  logic                    mem_valid_i;
  logic [WORD_WIDTH-1:0]   mem_data_i;
  logic [WAYS-1:0]         enable_way_o;
  logic                    port0_write_o;
  logic [3:0]              port0_enable_o;
  logic [CHIP_BITS-1:0]    port0_chip_select_o;
  logic [WORD_WIDTH/8-1:0] port0_byte_write_o;
  logic [INDEX_BITS-1:0]   port0_address_o;
  logic [WORD_WIDTH-1:0]   port0_word_o;
  logic [TAG_BITS-1:0]     port0_tag_o;
  logic                    port0_valid_o;
  logic                    port0_dirty_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    refill_error_o;

  modport master (
    input  miss_req_i, miss_address_i, miss_way_i, miss_store_i,
    input  mem_ack_i, mem_valid_i, mem_data_i,
    output miss_ready_o, mem_req_o, mem_address_o,
    output enable_way_o, port0_write_o, port0_enable_o, port0_chip_select_o,
    output port0_byte_write_o, port0_address_o, port0_word_o, port0_tag_o,
    output port0_valid_o, port0_dirty_o, busy_o, done_o, refill_error_o
  );

  modport slave (
    output miss_req_i, miss_address_i, miss_way_i, miss_store_i,
    output mem_ack_i, mem_valid_i, mem_data_i,
    input  miss_ready_o, mem_req_o, mem_address_o,
    input  enable_way_o, port0_write_o, port0_enable_o, port0_chip_select_o,
    input  port0_byte_write_o, port0_address_o, port0_word_o, port0_tag_o,
    input  port0_valid_o, port0_dirty_o, busy_o, done_o, refill_error_o
  );
endinterface

// File: rtl/data_cache_refill_unit.sv
// Data cache line-refill sequencer: invalidate, fetch a block word by word, commit tag/status.
// Optional refill watchdog enabled by defining DCACHE_REFILL_TIMEOUT_EN.
module data_cache_refill_unit #(
  parameter int WORD_WIDTH     = 32,
  parameter int BLOCK_WORDS    = 4,
  parameter int INDEX_BITS     = 8,
  parameter int TAG_BITS       = 20,
  parameter int WAYS           = 4,
  parameter int REFILL_TIMEOUT = 256
) (
  input logic                      clk_i,
  input logic                      rst_n_i,
  data_cache_refill_unit_if.master bus
);
  localparam int CHIP_BITS   = $clog2(BLOCK_WORDS);
  localparam int OFFSET_BITS = CHIP_BITS + 2;
  localparam int BYTES       = WORD_WIDTH / 8;
  localparam logic [CHIP_BITS-1:0] LAST_CHIP = CHIP_BITS'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {IDLE, INVALIDATE, REQUEST, RECEIVE, COMMIT} state_t;

  state_t                state, state_next;
  logic [CHIP_BITS-1:0]  chip;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [WAYS-1:0]       way;
  logic                  store;
  logic                  accept;
  logic                  word_fire;
  logic                  unused;

  assign unused = ^bus.miss_address_i[OFFSET_BITS-1:0];

`ifdef DCACHE_REFILL_TIMEOUT_EN
  localparam int WD_BITS = $clog2(REFILL_TIMEOUT + 1);
  logic [WD_BITS-1:0] wd_cnt;
  logic               error_q;
  logic               progress;
  logic               abort;
`endif

  always_comb begin
    state_next              = state;
    accept                  = (state == IDLE) && bus.miss_req_i;
    word_fire               = 1'b0;
    bus.miss_ready_o        = (state == IDLE);
    bus.busy_o              = (state != IDLE);
    bus.mem_req_o           = 1'b0;
    bus.mem_address_o       = '0;
    bus.enable_way_o        = '0;
    bus.port0_write_o       = 1'b0;
    bus.port0_enable_o      = 4'b0000;
    bus.port0_chip_select_o = '0;
    bus.port0_byte_write_o  = '0;
    bus.port0_address_o     = '0;
    bus.port0_word_o        = '0;
    bus.port0_tag_o         = '0;
    bus.port0_valid_o       = 1'b0;
    bus.port0_dirty_o       = 1'b0;
    bus.done_o              = 1'b0;
    bus.refill_error_o      = 1'b0;
    case (state)
      IDLE: if (accept) state_next = INVALIDATE;
      INVALIDATE: begin
        // Clear valid first so a partially refilled line can never hit.
        bus.port0_write_o      = 1'b1;
        bus.port0_enable_o     = 4'b1000;
        bus.port0_byte_write_o = {BYTES{1'b1}};
        bus.port0_address_o    = index;
        bus.enable_way_o       = way;
        state_next             = REQUEST;
      end
      REQUEST: begin
        bus.mem_req_o     = 1'b1;
        bus.mem_address_o = 32'({tag, index, {OFFSET_BITS{1'b0}}});
        if (bus.mem_ack_i) state_next = RECEIVE;
      end
      RECEIVE: begin
        if (bus.mem_valid_i) begin
          word_fire               = 1'b1;
          bus.port0_write_o       = 1'b1;
          bus.port0_enable_o      = 4'b0001;
          bus.port0_chip_select_o = chip;
          bus.port0_byte_write_o  = {BYTES{1'b1}};
          bus.port0_address_o     = index;
          bus.port0_word_o        = bus.mem_data_i;
          bus.enable_way_o        = way;
          if (chip == LAST_CHIP) state_next = COMMIT;
        end
      end
      COMMIT: begin
        bus.port0_write_o      = 1'b1;
        bus.port0_enable_o     = 4'b1110;
        bus.port0_byte_write_o = {BYTES{1'b1}};
        bus.port0_address_o    = index;
        bus.port0_tag_o        = tag;
        bus.port0_valid_o      = 1'b1;
        bus.port0_dirty_o      = store;
        bus.enable_way_o       = way;
        bus.done_o             = 1'b1;
        state_next             = IDLE;
      end
      default: state_next = IDLE;
    endcase
`ifdef DCACHE_REFILL_TIMEOUT_EN
    progress = accept || ((state == REQUEST) && bus.mem_ack_i) ||
               ((state == RECEIVE) && bus.mem_valid_i);
    abort    = ((state == REQUEST) || (state == RECEIVE)) && !progress &&
               (wd_cnt == WD_BITS'(REFILL_TIMEOUT - 1));
    if (abort) state_next = IDLE;
    bus.refill_error_o = error_q;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      chip  <= '0;
      index <= '0;
      tag   <= '0;
      way   <= '0;
      store <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        index <= bus.miss_address_i[OFFSET_BITS +: INDEX_BITS];
        tag   <= bus.miss_address_i[OFFSET_BITS + INDEX_BITS +: TAG_BITS];
        way   <= bus.miss_way_i;
        store <= bus.miss_store_i;
      end
      // The counter wraps to zero on the last word of the block.
      if (word_fire) chip <= chip + CHIP_BITS'(1);
`ifdef DCACHE_REFILL_TIMEOUT_EN
      if (abort) chip <= '0;
`endif
    end
  end

`ifdef DCACHE_REFILL_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= abort;
      if (progress) wd_cnt <= '0;
      else if ((state == REQUEST) || (state == RECEIVE)) wd_cnt <= wd_cnt + WD_BITS'(1);
    end
  end
`endif
endmodule

// File: tb/tb_data_cache_refill_unit.sv
// Scoreboard bench for data_cache_refill_unit: stimulus pushes expected port0 writes,
// a negedge monitor pops and compares every write the unit presents.
module tb_data_cache_refill_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_cache_refill_unit_if #(.WORD_WIDTH(32), .BLOCK_WORDS(4), .INDEX_BITS(8),
                              .TAG_BITS(20), .WAYS(4)) bus ();

  data_cache_refill_unit #(.WORD_WIDTH(32), .BLOCK_WORDS(4), .INDEX_BITS(8),
                           .TAG_BITS(20), .WAYS(4), .REFILL_TIMEOUT(256)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0]  en;
    logic [1:0]  chip;
    logic [31:0] word;
    logic [19:0] tag;
    logic        valid;
    logic        dirty;
    logic [7:0]  index;
    logic [3:0]  way;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  logic expect_error = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_exp(input logic [3:0] en, input int chip, input logic [31:0] word,
                          input logic [19:0] tag, input logic valid, input logic dirty,
                          input logic [7:0] index, input logic [3:0] way, input int done_cyc);
    exp_t x;
    x.en = en; x.chip = 2'(chip); x.word = word; x.tag = tag; x.valid = valid;
    x.dirty = dirty; x.index = index; x.way = way; x.done_cyc = done_cyc;
    sb.push_back(x);
  endtask

  // Monitor: every port0 write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.port0_write_o) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: enable 0x%0h chip %0d with empty scoreboard",
                 bus.port0_enable_o, bus.port0_chip_select_o);
      end else begin
        mon_e = sb.pop_front();
        chk("enable",     32'(bus.port0_enable_o),      32'(mon_e.en));
        chk("way",        32'(bus.enable_way_o),        32'(mon_e.way));
        chk("index",      32'(bus.port0_address_o),     32'(mon_e.index));
        chk("byte_write", 32'(bus.port0_byte_write_o),  32'hF);
        chk("chip",       32'(bus.port0_chip_select_o), 32'(mon_e.chip));
        chk("word",       bus.port0_word_o,             mon_e.word);
        chk("tag",        32'(bus.port0_tag_o),         32'(mon_e.tag));
        chk("valid",      32'(bus.port0_valid_o),       32'(mon_e.valid));
        chk("dirty",      32'(bus.port0_dirty_o),       32'(mon_e.dirty));
        chk("done",       32'(bus.done_o),              32'(mon_e.done_cyc >= 0));
        if (mon_e.done_cyc >= 0) chk("done_cycle", cyc, mon_e.done_cyc);
      end
    end else if (rst_n && bus.done_o) begin
      total++;
      $display("FAIL done_without_write: done_o=1 while port0_write_o=0 (cycle %0d)", cyc);
    end
    if (rst_n && bus.refill_error_o && !expect_error) begin
      total++;
      $display("FAIL spurious_error: refill_error_o=1 expected 0 (cycle %0d)", cyc);
    end
  end

  task automatic accept(input logic [31:0] addr, input logic [3:0] way, input logic store,
                        output int t);
    int n;
    n = 0;
    bus.miss_req_i     = 1'b1;
    bus.miss_address_i = addr;
    bus.miss_way_i     = way;
    bus.miss_store_i   = store;
    @(negedge clk);
    while (!bus.miss_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(bus.miss_ready_o), 32'h1);
    t = cyc;
  endtask

  task automatic serve(input logic [31:0] addr, input logic [3:0] way, input logic store,
                       input int t, input int done_lat, input int ack_delay, input int gap,
                       input logic [31:0] base, input logic stray, input int abort_words,
                       input logic keep_req, input logic [31:0] next_addr,
                       input logic [3:0] next_way);
    logic [7:0]  idx;
    logic [19:0] tg;
    int          n;
    idx = addr[11:4];
    tg  = addr[31:12];
    push_exp(4'b1000, 0, 32'h0, 20'h0, 1'b0, 1'b0, idx, way, -1);
    for (int i = 0; i < 4; i++)
      push_exp(4'b0001, i, base + 32'(i), 20'h0, 1'b0, 1'b0, idx, way, -1);
    push_exp(4'b1110, 0, 32'h0, tg, 1'b1, store, idx, way, t + done_lat);

    @(posedge clk); #1;
    if (!keep_req) bus.miss_req_i = 1'b0;
    else begin
      bus.miss_address_i = next_addr;
      bus.miss_way_i     = next_way;
    end
    @(posedge clk); #1;
    for (int d = 0; d <= ack_delay; d++) begin
      bus.mem_ack_i   = (d == ack_delay);
      bus.mem_valid_i = stray;
      bus.mem_data_i  = 32'hDEAD_BEEF;
      @(negedge clk);
      if (d == 0) begin
        chk("mem_req",          32'(bus.mem_req_o),    32'h1);
        chk("mem_address",      bus.mem_address_o,     {addr[31:4], 4'h0});
        chk("ready_while_busy", 32'(bus.miss_ready_o), 32'h0);
        if (stray) chk("stray_request_write", 32'(bus.port0_write_o), 32'h0);
      end
      @(posedge clk); #1;
    end
    bus.mem_ack_i   = 1'b0;
    bus.mem_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == abort_words) begin
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("rst_ready",   32'(bus.miss_ready_o),   32'h1);
        chk("rst_busy",    32'(bus.busy_o),         32'h0);
        chk("rst_write",   32'(bus.port0_write_o),  32'h0);
        chk("rst_enable",  32'(bus.port0_enable_o), 32'h0);
        chk("rst_way",     32'(bus.enable_way_o),   32'h0);
        chk("rst_mem_req", 32'(bus.mem_req_o),      32'h0);
        chk("rst_done",    32'(bus.done_o),         32'h0);
        #2 rst_n = 1'b1;
        return;
      end
      bus.mem_valid_i = 1'b1;
      bus.mem_data_i  = base + 32'(i);
      @(posedge clk); #1;
      bus.mem_valid_i = 1'b0;
      if (i < 3) repeat (gap) begin @(posedge clk); #1; end
    end
    n = 0;
    while (bus.busy_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_released", 32'(bus.busy_o), 32'h0);
  endtask

  initial begin
    int t, t2, n;
    bus.miss_req_i = 1'b0; bus.miss_address_i = '0; bus.miss_way_i = '0;
    bus.miss_store_i = 1'b0; bus.mem_ack_i = 1'b0; bus.mem_valid_i = 1'b0;
    bus.mem_data_i = '0;
    #2;
    chk("reset_ready",    32'(bus.miss_ready_o),   32'h1);
    chk("reset_busy",     32'(bus.busy_o),         32'h0);
    chk("reset_write",    32'(bus.port0_write_o),  32'h0);
    chk("reset_mem_req",  32'(bus.mem_req_o),      32'h0);
    chk("reset_done",     32'(bus.done_o),         32'h0);
    chk("reset_error",    32'(bus.refill_error_o), 32'h0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Load miss, ack on first request cycle, back-to-back words: done at T+7.
    accept(32'h0000_1230, 4'b0010, 1'b0, t);
    serve(32'h0000_1230, 4'b0010, 1'b0, t, 7, 0, 0, 32'hA0A0_0000, 1'b0, 4, 1'b0, 0, 0);

    // Store miss with 3-idle-cycle gaps: done 9 cycles later than back-to-back.
    accept(32'h8765_4320, 4'b0001, 1'b1, t);
    serve(32'h8765_4320, 4'b0001, 1'b1, t, 16, 0, 3, 32'h5150_0000, 1'b0, 4, 1'b0, 0, 0);

    // Stray mem_valid_i in IDLE, then in REQUEST with a 2-cycle ack delay.
    bus.mem_valid_i = 1'b1;
    bus.mem_data_i  = 32'h1234_5678;
    @(negedge clk);
    chk("stray_idle_write", 32'(bus.port0_write_o), 32'h0);
    chk("stray_idle_busy",  32'(bus.busy_o),        32'h0);
    @(posedge clk); #1;
    bus.mem_valid_i = 1'b0;
    accept(32'h0000_0FF0, 4'b1000, 1'b0, t);
    serve(32'h0000_0FF0, 4'b1000, 1'b0, t, 9, 2, 0, 32'hC0DE_0000, 1'b1, 4, 1'b0, 0, 0);

    // Request held through the refill: next one accepted the cycle after done_o.
    accept(32'h0001_2340, 4'b0100, 1'b0, t);
    serve(32'h0001_2340, 4'b0100, 1'b0, t, 7, 0, 0, 32'h1111_0000, 1'b0, 4,
          1'b1, 32'h0002_4680, 4'b0001);
    accept(32'h0002_4680, 4'b0001, 1'b0, t2);
    chk("held_accept_cycle", t2, t + 8);
    serve(32'h0002_4680, 4'b0001, 1'b0, t2, 10, 0, 1, 32'h2222_0000, 1'b0, 4, 1'b0, 0, 0);

    // Reset after two words, then a fresh miss must start at chip 0.
    accept(32'h0003_3330, 4'b0010, 1'b1, t);
    serve(32'h0003_3330, 4'b0010, 1'b1, t, 7, 0, 0, 32'h3333_0000, 1'b0, 2, 1'b0, 0, 0);
    @(posedge clk); #1;
    accept(32'h0000_5550, 4'b0010, 1'b0, t);
    serve(32'h0000_5550, 4'b0010, 1'b0, t, 7, 0, 0, 32'h5555_0000, 1'b0, 4, 1'b0, 0, 0);

`ifdef DCACHE_REFILL_TIMEOUT_EN
    // No ack at all: error pulse 256 stalled REQUEST cycles later, no commit.
    expect_error = 1'b1;
    accept(32'h0000_7770, 4'b0001, 1'b0, t);
    push_exp(4'b1000, 0, 32'h0, 20'h0, 1'b0, 1'b0, 8'h77, 4'b0001, -1);
    @(posedge clk); #1;
    bus.miss_req_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.refill_error_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_error",  32'(bus.refill_error_o), 32'h1);
    chk("timeout_cycle",  cyc, t + 258);
    chk("timeout_busy",   32'(bus.busy_o), 32'h0);
    @(posedge clk); #1;
    chk("timeout_pulse",  32'(bus.refill_error_o), 32'h0);
    expect_error = 1'b0;
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
